// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// It tracks register-use metadata for the EX, MEM and WB stages in a shadow
// pipeline. From that it derives:
//   - the EX forwarding selects,
//   - the load-use stall,
//   - the taken-branch flushes,
//   - a whole-pipeline freeze while data memory is busy.
// Saturating stall and flush counters are exposed for debug.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal flow; hazards and flushes act immediately
// MWAIT | a MEM-stage access is waiting on data memory; pipeline frozen

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_id_i,
  input  logic [4:0]       rs2_id_i,
  input  logic [4:0]       rd_id_i,
  input  logic             use_rs1_id_i,
  input  logic             use_rs2_id_i,
  input  logic             RegWEn_id_i,
  input  logic             is_load_id_i,
  input  logic             is_mem_id_i,
  input  logic             br_taken_ex_i,
  input  logic             dmem_busy_i,
  output logic [1:0]       Asel_haz_o,
  output logic [1:0]       Bsel_haz_o,
  output logic             stall_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  state_e state_q, state_d;

  // EX shadow stage
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       ex_use1, ex_use2, ex_wen, ex_load, ex_mem;
  // MEM shadow stage. The load flag is not carried past EX: the load-use
  // stall guarantees no consumer ever sits in EX with a load in MEM.
  logic [4:0] mem_rd;
  logic       mem_wen, mem_mem;
  // WB shadow stage
  logic [4:0] wb_rd;
  logic       wb_wen;

  logic       freeze;
  logic       ld_haz;
  logic       stall;
  logic       flush_ifid;
  logic       flush_idex;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign freeze = mem_mem & dmem_busy_i;

  assign ld_haz = ex_load & ex_wen & (ex_rd != 5'd0) &
                  ((use_rs1_id_i & (rs1_id_i == ex_rd)) |
                   (use_rs2_id_i & (rs2_id_i == ex_rd)));

  // Hazard resolution: freeze beats branch flush, which beats load-use
  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (freeze) begin
      // EX and ID are held, so deferred actions re-evaluate on unfreeze
      stall      = 1'b0;
    end else if (br_taken_ex_i) begin
      // the ID instruction is discarded, so any load-use hazard is moot
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (ld_haz) begin
      stall      = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (freeze) state_d = MWAIT;
      MWAIT:   if (!dmem_busy_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow pipeline advance; everything holds while frozen
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_rs1  <= 5'd0;
      ex_rs2  <= 5'd0;
      ex_rd   <= 5'd0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
      ex_wen  <= 1'b0;
      ex_load <= 1'b0;
      ex_mem  <= 1'b0;
      mem_rd  <= 5'd0;
      mem_wen <= 1'b0;
      mem_mem <= 1'b0;
      wb_rd   <= 5'd0;
      wb_wen  <= 1'b0;
    end else if (!freeze) begin
      if (flush_idex) begin
        ex_rs1  <= 5'd0;
        ex_rs2  <= 5'd0;
        ex_rd   <= 5'd0;
        ex_use1 <= 1'b0;
        ex_use2 <= 1'b0;
        ex_wen  <= 1'b0;
        ex_load <= 1'b0;
        ex_mem  <= 1'b0;
      end else begin
        ex_rs1  <= rs1_id_i;
        ex_rs2  <= rs2_id_i;
        ex_rd   <= rd_id_i;
        ex_use1 <= use_rs1_id_i;
        ex_use2 <= use_rs2_id_i;
        ex_wen  <= RegWEn_id_i;
        ex_load <= is_load_id_i;
        ex_mem  <= is_mem_id_i;
      end
      mem_rd  <= ex_rd;
      mem_wen <= ex_wen;
      mem_mem <= ex_mem;
      wb_rd   <= mem_rd;
      wb_wen  <= mem_wen;
    end
  end

  // Forwarding selects; MEM is younger than WB so it wins, x0 never forwards
  always_comb begin
    Asel_haz_o = SEL_RF;
    Bsel_haz_o = SEL_RF;
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs1) && ex_use1) begin
      Asel_haz_o = SEL_MEM;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs1) && ex_use1) begin
      Asel_haz_o = SEL_WB;
    end
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs2) && ex_use2) begin
      Bsel_haz_o = SEL_MEM;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs2) && ex_use2) begin
      Bsel_haz_o = SEL_WB;
    end
  end

  // Saturating debug counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall || freeze) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_ifid && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_o      = stall;
  assign flush_ifid_o = flush_ifid;
  assign flush_idex_o = flush_idex;
  assign freeze_o     = freeze;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule
